very_simple_cpu: RTL and testbench
==================================

// Module: very_simple_cpu
// PURPOSE
// - Multi-cycle 32-bit memory-to-memory CPU (VSCPU ISA); no register file, every operand is a RAM word.
// - Sits beside one synchronous single-port RAM: 1-cycle read latency, write on clk edge when wrEn=1.
// - Executes from address 0 after reset; fetch, operand reads and result writes share one port.
// PARAMETERS
// - ADDR_W  14  word-address width; A/B instruction fields, PC and addr_toRAM are this wide.
// PORTS
// - clk           in   1       system clock, rising edge
// - rst           in   1       reset, asynchronous, active-high
// - wrEn          out  1       RAM write enable
// - data_fromRAM  in   32      RAM read data; valid the cycle after the address is presented
// - addr_toRAM    out  ADDR_W  RAM address
// - data_toRAM    out  32      RAM write data
// BEHAVIOUR
// - Instruction word IW: [31:29] op, [28] imm, [27:14] A, [13:0] B. Immediate = B zero-extended to 32 bits.
// - Ops (*X = mem[X]; imm=0 form / imm=1 form):
//   - 0 ADD:  *A <= *A + *B      / *A <= *A + B   (mod 2^32)
//   - 1 NAND: *A <= ~(*A & *B)   / with B
//   - 2 SRL:  s = *B (or B); *A <= (s<32) ? *A>>s (logical) : *A<<(s-32)
//   - 3 LT:   *A <= (*A < *B) ? 1 : 0 (unsigned) / with B
//   - 4 CP:   *A <= *B           / *A <= B
//   - 5 CPI:  *A <= *(*B)        / *(*A) <= *B
//   - 6 BZJ:  PC <= (*B==0) ? *A : PC+1 / PC <= *A + B; no memory write
//   - 7 MUL:  *A <= low 32 bits of *A * *B / with B
// - Pointers (*A, *B used as addresses or jump targets) are truncated to their low ADDR_W bits.
// - State registers: state, PC, IW, R1 (*A), R2 (*B); all update on posedge clk.
// - Outputs are combinational from the registers.
// - FSM (each state one cycle):
//   - FETCH:  addr=PC -> DECODE
//   - DECODE: IW<=data; addr=A -> RDA
//   - RDA:    R1<=data; addr=B -> EXEC
//   - EXEC:   R2<=data; performs the op:
//     - ALU/CP ops: wrEn=1, addr=A, data=result; PC<=PC+1 -> FETCH
//     - CPIi: wrEn=1, addr=R1, data=*B; PC+1 -> FETCH
//     - CPI: addr=*B -> IND
//     - BZJ/BZJi: wrEn=0, PC<=target -> FETCH
//   - IND:    wrEn=1, addr=A, data=data_fromRAM; PC+1 -> FETCH
// - Timing: CPI takes 5 cycles; every other instruction takes 4.
// - *A and *B are read even for immediate forms, where the value is unused.
// - A=B is legal: both reads return the same word.
// - wrEn: high for exactly one cycle per writing instruction, never in FETCH/DECODE/RDA.
// - PC increments modulo 2^ADDR_W; execution continues past the last address by wrap-around.
// - Reset (any cycle, including mid-instruction): state=FETCH, PC=0, IW=R1=R2=0.
//   - Outputs during reset: wrEn=0, addr_toRAM=0, data_toRAM=0.
//   - An in-flight write is abandoned; fetch of address 0 starts on the first clock after release.
// - No halt instruction; a program stops by BZJ looping on itself.
// TESTING
// - Reset release, mem[0]=ADD A=100 B=101 (32'h0019_0065), mem[100]=5, mem[101]=7:
//   - -> cycle 4 wrEn=1, addr=100, data=12; next fetch addr=1.
// - ADDi A=100 B=1 with mem[100]=32'hFFFFFFFF -> mem[100]=0.
// - LTi with *A=3, B=9 -> mem[A]=1.
// - SRL with *B=33, *A=32'h8000_0001 -> mem[A]=32'h0000_0002.
// - SRL with *B=4, *A=32'hF0 -> mem[A]=32'h0F.
// - CPI A=110 B=111, mem[111]=120, mem[120]=77 -> mem[110]=77 after 5 cycles.
// - CPIi A=110 B=111, mem[110]=130, mem[111]=9 -> mem[130]=9.
// - BZJ, *B=0, *A=40 -> next fetch addr 40.
// - BZJ, *B=1 -> next fetch addr PC+1.
// - BZJi, *A=3, B=17 -> next fetch addr 20.
// - MUL with *A=32'h10000, *B=32'h10001 -> mem[A]=32'h0001_0000.
// - Assert rst in EXEC of a writing instruction -> wrEn drops immediately, no write.
//   - After release, refetch from addr 0.

Source files
------------

// File: rtl/very_simple_cpu.sv
// Multi-cycle memory-to-memory CPU for the VSCPU ISA.
// Every operand lives in the attached single-port synchronous RAM.
// Fetch, operand reads and the result write all share that one port, so each
// instruction walks FETCH -> DECODE -> RDA -> EXEC, plus IND for the
// doubly-indirect CPI form.
module very_simple_cpu #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  output logic              wrEn,
  input  logic [31:0]       data_fromRAM,
  output logic [ADDR_W-1:0] addr_toRAM,
  output logic [31:0]       data_toRAM
);

  typedef enum logic [2:0] {FETCH, DECODE, RDA, EXEC, IND} state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       iw;
  logic [31:0]       r1;   // *A
  logic [31:0]       r2;   // *B, captured at the end of EXEC

  // R2 is architectural state kept for visibility; no path consumes it.
  logic unused_r2;
  assign unused_r2 = ^r2;

  logic [2:0]        op;
  logic              imm;
  logic [13:0]       a_fld;
  logic [13:0]       b_fld;
  logic [31:0]       imm_val;
  logic [31:0]       opnd;
  logic [31:0]       alu_res;
  logic [31:0]       jmp_sum;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] bzj_target;

  assign op      = iw[31:29];
  assign imm     = iw[28];
  assign a_fld   = iw[27:14];
  assign b_fld   = iw[13:0];
  assign imm_val = {18'd0, b_fld};
  // In EXEC the RAM is returning *B, so the second operand comes straight off the bus.
  assign opnd    = imm ? imm_val : data_fromRAM;
  assign pc_inc  = pc + ADDR_W'(1);
  assign jmp_sum = r1 + imm_val;

  // Branch target: BZJi jumps to *A + B, BZJ jumps to *A only when *B is zero.
  always_comb begin
    bzj_target = pc_inc;
    if (imm)
      bzj_target = jmp_sum[ADDR_W-1:0];
    else if (data_fromRAM == 32'd0)
      bzj_target = r1[ADDR_W-1:0];
  end

  // Result of the arithmetic/copy ops, using *A from R1 and *B or B as operand.
  always_comb begin
    alu_res = 32'd0;
    case (op)
      OP_ADD:  alu_res = r1 + opnd;
      OP_NAND: alu_res = ~(r1 & opnd);
      OP_SRL:  alu_res = (opnd < 32'd32) ? (r1 >> opnd) : (r1 << (opnd - 32'd32));
      OP_LT:   alu_res = (r1 < opnd) ? 32'd1 : 32'd0;
      OP_CP:   alu_res = opnd;
      OP_MUL:  alu_res = r1 * opnd;
      default: alu_res = 32'd0;
    endcase
  end

  // RAM port drive: address/data/enable decoded from the current state.
  always_comb begin
    wrEn       = 1'b0;
    addr_toRAM = '0;
    data_toRAM = 32'd0;
    case (state)
      FETCH:  addr_toRAM = pc;
      // IW is not loaded yet, so the A field is taken from the returning word.
      DECODE: addr_toRAM = ADDR_W'(data_fromRAM[27:14]);
      RDA:    addr_toRAM = ADDR_W'(b_fld);
      EXEC: begin
        if (op == OP_CPI) begin
          if (imm) begin
            wrEn       = 1'b1;
            addr_toRAM = r1[ADDR_W-1:0];
            data_toRAM = data_fromRAM;
          end else begin
            addr_toRAM = data_fromRAM[ADDR_W-1:0];
          end
        end else if (op != OP_BZJ) begin
          wrEn       = 1'b1;
          addr_toRAM = ADDR_W'(a_fld);
          data_toRAM = alu_res;
        end
      end
      IND: begin
        wrEn       = 1'b1;
        addr_toRAM = ADDR_W'(a_fld);
        data_toRAM = data_fromRAM;
      end
      default: ;
    endcase
  end

  // Sequencer and architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      iw    <= 32'd0;
      r1    <= 32'd0;
      r2    <= 32'd0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          iw    <= data_fromRAM;
          state <= RDA;
        end
        RDA: begin
          r1    <= data_fromRAM;
          state <= EXEC;
        end
        EXEC: begin
          r2 <= data_fromRAM;
          if (op == OP_CPI && !imm) begin
            state <= IND;
          end else begin
            state <= FETCH;
            pc    <= (op == OP_BZJ) ? bzj_target : pc_inc;
          end
        end
        IND: begin
          pc    <= pc_inc;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_very_simple_cpu.sv
// Bench for very_simple_cpu: behavioural RAM plus an instruction-level ISA
// model; each instruction's RAM-port activity is compared against the model.
module tb_very_simple_cpu;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wrEn;
  logic [31:0]   data_fromRAM = 32'd0;
  logic [AW-1:0] addr_toRAM;
  logic [31:0]   data_toRAM;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int ref_pc = 0;
  int total  = 0;
  int bad    = 0;

  very_simple_cpu #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .data_fromRAM(data_fromRAM),
    .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM, read-before-write
  always @(posedge clk) begin
    data_fromRAM <= mem[addr_toRAM];
    if (wrEn) mem[addr_toRAM] = data_toRAM;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int imm, input int a, input int b);
    return {op[2:0], imm[0], a[13:0], b[13:0]};
  endfunction

  task automatic poke(input int a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
  endtask

  task automatic rst_on();
    rst = 1'b1;
    #1;
    chk("rst_wren", 32'(wrEn), 32'd0);
    chk("rst_addr", 32'(addr_toRAM), 32'd0);
    chk("rst_data", data_toRAM, 32'd0);
  endtask

  task automatic rst_off();
    @(negedge clk);
    rst = 1'b0;
    ref_pc = 0;
  endtask

  task automatic chk_next();
    #1;
    chk("next_fetch", 32'(addr_toRAM), 32'(ref_pc));
    chk("fetch_wren", 32'(wrEn), 32'd0);
  endtask

  // Execute one instruction in the ISA model and check the DUT port cycle by cycle.
  task automatic step();
    logic [31:0] iw, va, vb, opnd, res, t;
    logic [2:0]  op;
    logic        imm;
    int a, b, ncyc, waddr, npc;
    bit wr;
    iw   = ref_mem[ref_pc];
    op   = iw[31:29];
    imm  = iw[28];
    a    = int'(iw[27:14]);
    b    = int'(iw[13:0]);
    va   = ref_mem[a];
    vb   = ref_mem[b];
    opnd = imm ? 32'(b) : vb;
    ncyc = 4; wr = 1'b1; waddr = a; res = 32'd0;
    npc  = (ref_pc + 1) % DEPTH;
    case (op)
      3'd0: res = va + opnd;
      3'd1: res = ~(va & opnd);
      3'd2: res = (opnd < 32) ? (va >> opnd) : (va << (opnd - 32));
      3'd3: res = (va < opnd) ? 32'd1 : 32'd0;
      3'd4: res = opnd;
      3'd5: if (imm) begin
              waddr = int'(va % DEPTH);
              res = vb;
            end else begin
              res = ref_mem[vb % DEPTH];
              ncyc = 5;
            end
      3'd6: begin
              wr = 1'b0;
              t = va + 32'(b);
              if (imm) npc = int'(t % DEPTH);
              else if (vb == 0) npc = int'(va % DEPTH);
            end
      default: res = va * opnd;
    endcase
    for (int c = 1; c <= ncyc; c++) begin
      #1;
      if (c == 1) chk("fetch_addr", 32'(addr_toRAM), 32'(ref_pc));
      chk("wren", 32'(wrEn), (c == ncyc && wr) ? 32'd1 : 32'd0);
      if (c == ncyc && wr) begin
        chk("waddr", 32'(addr_toRAM), 32'(waddr));
        chk("wdata", data_toRAM, res);
      end
      @(negedge clk);
    end
    if (wr) ref_mem[waddr] = res;
    ref_pc = npc;
  endtask

  initial begin
    int diffs;
    #2;
    // basic ADD from reset
    rst_on();
    clear_mem();
    poke(0, 32'h0019_0065);
    poke(100, 32'd5);
    poke(101, 32'd7);
    rst_off();
    step();
    chk_next();
    chk("add_result", mem[100], 32'd12);

    // reset during EXEC of a writing instruction
    rst_on();
    clear_mem();
    poke(0, 32'h0019_0065);
    poke(100, 32'd5);
    poke(101, 32'd7);
    rst_off();
    repeat (3) @(negedge clk);
    #1;
    chk("exec_wren", 32'(wrEn), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_wren", 32'(wrEn), 32'd0);
    chk("midrst_addr", 32'(addr_toRAM), 32'd0);
    chk("midrst_data", data_toRAM, 32'd0);
    @(negedge clk);
    chk("no_write", mem[100], 32'd5);
    rst = 1'b0;
    ref_pc = 0;
    step();
    chk("refetch_add", mem[100], 32'd12);

    // directed program covering each op
    rst_on();
    clear_mem();
    poke(0,  enc(0, 1, 100, 1));   poke(100, 32'hFFFF_FFFF);
    poke(1,  enc(3, 1, 102, 9));   poke(102, 32'd3);
    poke(2,  enc(2, 0, 103, 104)); poke(103, 32'h8000_0001); poke(104, 32'd33);
    poke(3,  enc(2, 0, 105, 106)); poke(105, 32'hF0);        poke(106, 32'd4);
    poke(4,  enc(5, 0, 110, 111)); poke(111, 32'd120);       poke(120, 32'd77);
    poke(5,  enc(5, 1, 112, 113)); poke(112, 32'd130);       poke(113, 32'd9);
    poke(6,  enc(7, 0, 114, 115)); poke(114, 32'h1_0000);    poke(115, 32'h1_0001);
    poke(7,  enc(6, 0, 116, 117)); poke(116, 32'd40);        poke(117, 32'd0);
    poke(40, enc(0, 0, 126, 126)); poke(126, 32'd21);
    poke(41, enc(6, 0, 118, 119)); poke(118, 32'd99);        poke(119, 32'd1);
    poke(42, enc(6, 1, 121, 17));  poke(121, 32'd3);
    poke(20, enc(6, 0, 122, 123)); poke(122, 32'd20);        poke(123, 32'd0);
    rst_off();
    repeat (13) step();
    chk_next();
    chk("loop_pc", 32'(addr_toRAM), 32'd20);
    chk("addi_wrap", mem[100], 32'd0);
    chk("lti", mem[102], 32'd1);
    chk("srl_big", mem[103], 32'h0000_0002);
    chk("srl_small", mem[105], 32'h0000_000F);
    chk("cpi", mem[110], 32'd77);
    chk("cpii", mem[130], 32'd9);
    chk("mul", mem[114], 32'h0001_0000);
    chk("add_a_eq_b", mem[126], 32'd42);

    // PC wrap past the last address
    rst_on();
    clear_mem();
    poke(0, enc(6, 1, 124, 0));
    poke(124, 32'd16383);
    poke(16383, enc(0, 1, 100, 1));
    poke(100, 32'd41);
    rst_off();
    repeat (2) step();
    chk_next();
    chk("wrap_pc", 32'(addr_toRAM), 32'd0);
    chk("wrap_add", mem[100], 32'd42);

    // random programs against the ISA model
    rst_on();
    clear_mem();
    for (int i = 0; i < 32; i++) begin
      int op, im, a, b;
      op = int'($urandom_range(0, 7));
      im = int'($urandom_range(0, 1));
      a  = 64 + int'($urandom_range(0, 15));
      b  = (im != 0) ? int'($urandom_range(0, 40)) : 64 + int'($urandom_range(0, 15));
      poke(i, enc(op, im, a, b));
    end
    for (int i = 64; i < 80; i++)
      poke(i, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom);
    rst_off();
    repeat (300) step();
    chk_next();
    diffs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    chk("rand_mem_diffs", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
